// File: rtl/multicycle_seq.sv
// multicycle_seq: instruction sequencer for the multi-cycle RV32I core.
// It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB.
// It owns the PC and the instruction register (IR).
// It gates the register-file and CSR write strobes so that each instruction commits once.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   imem_*             instruction fetch handshake (req/addr out, ready/rdata in)
//   pc_address         PC register
//   instruction        IR, feeds the combinational CU / imm_generator / Reg_File
//   next_pc            next PC from PC_update
//   mem_read, mem_write, reg_write, csr_write_enable   CU decode of IR
//   dmem_req, dmem_we  data access request and write qualifier; dmem_ready completes it
//   rf_we, csr_we      gated write strobes; retire pulses once per commit
//   halted, halt_cause 01 = ECALL/EBREAK, 10 = misaligned next_pc
//   cycle_count, instret_count  performance counters
//
// Optional feature: define RV_PERF_COUNTERS_EN to build the counters.
// Without it, cycle_count and instret_count are tied to 0.
module multicycle_seq #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic [XLEN-1:0]      pc_address,
  output logic [31:0]          instruction,
  input  logic [XLEN-1:0]      next_pc,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  input  logic                 csr_write_enable,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  output logic                 rf_we,
  output logic                 csr_we,
  output logic                 retire,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0] cause_q, cause_d;
  logic is_sys, is_mem, misaligned;
  always_comb begin
    is_sys = (ir_q == ECALL) || (ir_q == EBREAK);
    is_mem = mem_read | mem_write;
    misaligned = |next_pc[1:0];
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    cause_d = cause_q;
    case (state_q)
      FETCH: begin
        ir_d = imem_ready ? imem_rdata : ir_q;
        state_d = imem_ready ? DECODE : FETCH;
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        state_d = is_sys ? HALT : is_mem ? MEM : WB;
        cause_d = is_sys ? 2'b01 : cause_q;
      end
      MEM: state_d = dmem_ready ? WB : MEM;
      // A misaligned target still commits this instruction, but the PC keeps its value.
      WB: begin
        state_d = misaligned ? HALT : FETCH;
        cause_d = misaligned ? 2'b10 : cause_q;
        pc_d = misaligned ? pc_q : next_pc;
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      ir_q <= NOP;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      cause_q <= cause_d;
    end
  end
  // Strobes are decoded from the state register.
  // They are masked by rst so that an abort drops requests and commits in the same cycle.
  assign imem_req = !rst && state_q == FETCH;
  assign dmem_req = !rst && state_q == MEM;
  assign dmem_we = dmem_req && mem_write;
  assign retire = !rst && state_q == WB;
  assign rf_we = retire && reg_write;
  assign csr_we = retire && csr_write_enable;
  assign imem_addr = pc_q;
  assign pc_address = pc_q;
  assign instruction = ir_q;
  assign halted = state_q == HALT;
  assign halt_cause = cause_q;
`ifdef RV_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cyc_q, ret_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= halted ? cyc_q : cyc_q + CNT_WIDTH'(1);
      ret_q <= ret_q + CNT_WIDTH'(retire);
    end
  end
  assign cycle_count = cyc_q;
  assign instret_count = ret_q;
`else
  assign cycle_count = '0;
  assign instret_count = '0;
`endif
endmodule
